convnet: RTL and testbench

CONVNET -- requirements
Module: convnet

---
 rtl/convnet.sv | 198 +++++++++++++++++++
 tb/tb_convnet.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/convnet.sv
// FX2 slave-FIFO to Wishbone batch mover: reads NWORDS 32-bit words from the FX2 OUT FIFO,
// writes them to memory, reads them back, streams them to the FX2 IN FIFO, then commits
// the packet with pktend and bumps the batch counter.
module convnet #(
  parameter int unsigned NWORDS = 8
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        FLAGA,
  input  logic        FLAGD,
  output logic [1:0]  FIFOADR,
  output logic        SLRD,
  output logic        SLWR,
  output logic        SLOE,
  output logic        pktend,
  output logic        IFCLK,
  inout  wire  [15:0] FDATA,
  output logic [3:0]  LED,
  output logic [3:0]  cstate,
  output logic        cyc_i,
  output logic        stb_i,
  output logic        we_i,
  output logic [3:0]  sel_i,
  output logic [31:0] addr_i,
  output logic [31:0] data_i,
  input  logic [31:0] data_o,
  input  logic        sdram_ack,
  input  logic        stall_o
);

  // 7 bits covers the largest legal batch of 120 words
  localparam logic [6:0] KLast = 7'(NWORDS - 1);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StRdLo   = 4'd1,
    StRdHi   = 4'd2,
    StWbWr   = 4'd3,
    StWbRd   = 4'd4,
    StWrLo   = 4'd5,
    StWrHi   = 4'd6,
    StPktend = 4'd7,
    StDone   = 4'd8
  } state_e;

  state_e      r_state, w_state_d;
  logic [6:0]  r_k, w_k_d;
  logic [31:0] r_word, w_word_d;    // word assembled from FX2, written to memory
  logic [31:0] r_rdata, w_rdata_d;  // word read back from memory, sent to FX2
  logic        r_arm, w_arm_d;      // write half has had FDATA on the bus for a cycle
  logic [3:0]  r_led, w_led_d;
  logic        w_fdata_oe;
  logic [15:0] w_fdata_out;
  logic [15:0] w_fdata_in;
  logic        w_unused;

  // Every request stays on the bus until acked, so stall needs no extra handling.
  assign w_unused   = stall_o;
  assign IFCLK      = CLK;
  assign FDATA      = w_fdata_oe ? w_fdata_out : 16'hzzzz;
  assign w_fdata_in = FDATA;
  assign cstate     = r_state;
  assign LED        = r_led;
  assign addr_i     = 32'(r_k);
  assign data_i     = r_word;

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (rst_n) begin
      r_state <= StIdle;
      r_k     <= '0;
      r_word  <= '0;
      r_rdata <= '0;
      r_arm   <= 1'b0;
      r_led   <= '0;
    end else begin
      r_state <= w_state_d;
      r_k     <= w_k_d;
      r_word  <= w_word_d;
      r_rdata <= w_rdata_d;
      r_arm   <= w_arm_d;
      r_led   <= w_led_d;
    end
  end

  // Next-state, datapath updates and strobe/bus decode from the current state.
  always_comb begin
    w_state_d   = r_state;
    w_k_d       = r_k;
    w_word_d    = r_word;
    w_rdata_d   = r_rdata;
    w_arm_d     = r_arm;
    w_led_d     = r_led;
    FIFOADR     = 2'b00;
    SLRD        = 1'b1;
    SLWR        = 1'b1;
    SLOE        = 1'b1;
    pktend      = 1'b1;
    cyc_i       = 1'b0;
    stb_i       = 1'b0;
    we_i        = 1'b0;
    sel_i       = 4'h0;
    w_fdata_oe  = 1'b0;
    w_fdata_out = 16'h0000;

    unique case (r_state)
      StIdle: begin
        if (FLAGA) begin
          w_k_d     = '0;
          w_state_d = StRdLo;
        end
      end
      StRdLo: begin
        SLOE = 1'b0;
        if (FLAGA) begin
          SLRD           = 1'b0;
          w_word_d[15:0] = w_fdata_in;
          w_state_d      = StRdHi;
        end
      end
      StRdHi: begin
        SLOE = 1'b0;
        if (FLAGA) begin
          SLRD            = 1'b0;
          w_word_d[31:16] = w_fdata_in;
          w_state_d       = StWbWr;
        end
      end
      StWbWr: begin
        cyc_i = 1'b1;
        stb_i = 1'b1;
        we_i  = 1'b1;
        sel_i = 4'hF;
        if (sdram_ack) begin
          if (r_k < KLast) begin
            w_k_d     = r_k + 7'd1;
            w_state_d = StRdLo;
          end else begin
            w_k_d     = '0;
            w_state_d = StWbRd;
          end
        end
      end
      StWbRd: begin
        cyc_i = 1'b1;
        stb_i = 1'b1;
        sel_i = 4'hF;
        if (sdram_ack) begin
          w_rdata_d = data_o;
          w_state_d = StWrLo;
        end
      end
      StWrLo: begin
        FIFOADR     = 2'b10;
        w_fdata_oe  = 1'b1;
        w_fdata_out = r_rdata[15:0];
        if (!r_arm) begin
          w_arm_d = 1'b1;
        end else if (!FLAGD) begin
          SLWR      = 1'b0;
          w_arm_d   = 1'b0;
          w_state_d = StWrHi;
        end
      end
      StWrHi: begin
        FIFOADR     = 2'b10;
        w_fdata_oe  = 1'b1;
        w_fdata_out = r_rdata[31:16];
        if (!r_arm) begin
          w_arm_d = 1'b1;
        end else if (!FLAGD) begin
          SLWR    = 1'b0;
          w_arm_d = 1'b0;
          if (r_k < KLast) begin
            w_k_d     = r_k + 7'd1;
            w_state_d = StWbRd;
          end else begin
            w_state_d = StPktend;
          end
        end
      end
      StPktend: begin
        FIFOADR   = 2'b10;
        pktend    = 1'b0;
        w_state_d = StDone;
      end
      StDone: begin
        w_led_d   = r_led + 4'd1;
        w_k_d     = '0;
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_convnet.sv
// Scoreboard bench for convnet: FX2 source/sink models, a Wishbone memory with slow acks and
// stalls, and monitors that pop expected words whenever the DUT presents a transfer.
module tb_convnet;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        FLAGA, FLAGD;
  logic [1:0]  FIFOADR;
  logic        SLRD, SLWR, SLOE, pktend, IFCLK;
  wire  [15:0] FDATA;
  logic [3:0]  LED, cstate;
  logic        cyc_i, stb_i, we_i;
  logic [3:0]  sel_i;
  logic [31:0] addr_i, data_i, data_o;
  logic        sdram_ack, stall_o;

  logic [15:0] src = 16'd0;
  logic [31:0] mem [8];
  int          wr_cnt [8];
  logic [31:0] exp_wr_addr[$];
  logic [31:0] exp_wr_data[$];
  logic [15:0] exp_fx[$];
  int n_checks = 0, n_pass = 0;
  int slwr_cnt = 0, pk_cnt = 0, viol = 0, stab_err = 0, cyc_n = 0;
  bit flag_en = 1'b0;

  always #5 CLK = ~CLK;

  // FX2 drives the bus only while the DUT has its output enable asserted.
  assign FDATA = (SLOE == 1'b0) ? src : 16'hzzzz;

  convnet #(.NWORDS(8)) dut (
    .CLK(CLK), .rst_n(rst_n), .FLAGA(FLAGA), .FLAGD(FLAGD), .FIFOADR(FIFOADR),
    .SLRD(SLRD), .SLWR(SLWR), .SLOE(SLOE), .pktend(pktend), .IFCLK(IFCLK), .FDATA(FDATA),
    .LED(LED), .cstate(cstate), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .sel_i(sel_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_o), .sdram_ack(sdram_ack),
    .stall_o(stall_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // FX2 source: advance the OUT FIFO after each edge that consumed a word.
  initial begin : fx2_src
    bit take;
    forever begin
      @(negedge CLK);
      take = (SLRD == 1'b0) && FLAGA && !rst_n;
      @(posedge CLK);
      #1;
      if (take) src = src + 16'd1;
    end
  end

  // Flag pattern: FIFO briefly empty on the read side, briefly full on the write side.
  initial begin : flags
    forever begin
      @(posedge CLK);
      #1;
      cyc_n++;
      if (flag_en) begin
        FLAGA = !((cyc_n % 9) == 4 || (cyc_n % 9) == 5);
        FLAGD = (cyc_n % 5) == 2;
      end
    end
  end

  // Memory: ack six cycles after the request, stalling odd addresses for the first three.
  initial begin : mem_model
    logic [31:0] s_addr, s_data;
    logic        s_we;
    bit          aborted;
    sdram_ack = 1'b0;
    stall_o   = 1'b0;
    data_o    = 32'hdead_beef;
    forever begin
      @(negedge CLK);
      if (cyc_i && stb_i && !rst_n) begin
        s_addr  = addr_i;
        s_data  = data_i;
        s_we    = we_i;
        aborted = 1'b0;
        for (int c = 0; c < 6 && !aborted; c++) begin
          @(posedge CLK);
          #1;
          stall_o = (c < 3) && s_addr[0];
          @(negedge CLK);
          if (!cyc_i) aborted = 1'b1;
          else if (!stb_i || addr_i != s_addr || data_i != s_data || we_i != s_we) stab_err++;
        end
        stall_o = 1'b0;
        if (!aborted) begin
          @(posedge CLK);
          #1;
          sdram_ack = 1'b1;
          if (s_we) mem[s_addr[2:0]] = s_data;
          else data_o = mem[s_addr[2:0]];
          @(posedge CLK);
          #1;
          sdram_ack = 1'b0;
          data_o    = 32'hdead_beef;
        end
      end
    end
  end

  // Monitors: Wishbone writes, FX2 IN-FIFO writes, pktend, and strobe/handshake rules.
  initial begin : monitors
    logic [15:0] p_fdata;
    logic        p_oe_ok, p_flaga;
    logic [3:0]  p_state;
    int          lows;
    p_fdata = '0; p_oe_ok = 1'b0; p_flaga = 1'b0; p_state = '0;
    forever begin
      @(negedge CLK);
      if (!rst_n) begin
        if (cyc_i && stb_i && we_i && sdram_ack) begin
          if (exp_wr_addr.size() == 0) begin
            n_checks++;
            $display("FAIL wb_wr_extra: got write addr %h, expected none", addr_i);
          end else begin
            chk("wb_wr_addr", addr_i, exp_wr_addr.pop_front());
            chk("wb_wr_data", data_i, exp_wr_data.pop_front());
            chk("wb_wr_sel", {28'd0, sel_i}, 32'h0000_000F);
            if (addr_i < 8) wr_cnt[addr_i[2:0]]++;
          end
        end
        if (SLWR == 1'b0) begin
          slwr_cnt++;
          if (exp_fx.size() == 0) begin
            n_checks++;
            $display("FAIL fx2_extra: got word %h, expected none", FDATA);
          end else begin
            chk("fx2_word", {16'd0, FDATA}, {16'd0, exp_fx.pop_front()});
          end
          if (FLAGD || FIFOADR != 2'b10 || !p_oe_ok || FDATA != p_fdata) viol++;
        end
        if (pktend == 1'b0) begin
          pk_cnt++;
          chk("pktend_after_16_writes", slwr_cnt, 16);
        end
        lows = int'(!SLRD) + int'(!SLWR) + int'(!pktend);
        if (lows > 1) viol++;
        if (SLRD == 1'b0 && (SLOE != 1'b0 || FIFOADR != 2'b00 || !FLAGA)) viol++;
        if ((p_state == 4'd1 || p_state == 4'd2) && !p_flaga && cstate != p_state) viol++;
      end
      p_fdata = FDATA;
      p_oe_ok = (SLOE == 1'b1) && (FIFOADR == 2'b10) && (cstate == 4'd5 || cstate == 4'd6);
      p_flaga = FLAGA;
      p_state = cstate;
    end
  end

  initial begin : main
    rst_n = 1'b1;
    FLAGA = 1'b0;
    FLAGD = 1'b0;
    for (int k = 0; k < 8; k++) begin
      mem[k]    = 32'h0;
      wr_cnt[k] = 0;
      exp_wr_addr.push_back(32'(k));
      exp_wr_data.push_back({16'(2 * k + 1), 16'(2 * k)});
    end
    for (int i = 0; i < 16; i++) exp_fx.push_back(16'(i));

    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("rst_cstate", {28'd0, cstate}, 32'd0);
    chk("rst_strobes", {28'd0, SLRD, SLWR, SLOE, pktend}, 32'hF);
    chk("rst_fifoadr", {30'd0, FIFOADR}, 32'd0);
    chk("rst_fdata_z", {31'd0, FDATA === 16'hzzzz}, 32'd1);
    chk("rst_led", {28'd0, LED}, 32'd0);
    chk("rst_bus_ctl", {25'd0, cyc_i, stb_i, we_i, sel_i}, 32'd0);
    chk("rst_addr", addr_i, 32'd0);
    chk("rst_data", data_i, 32'd0);

    @(posedge CLK);
    #1;
    chk("ifclk_follows_clk", {31'd0, IFCLK}, 32'd1);
    rst_n = 1'b0;
    repeat (6) @(negedge CLK);
    chk("idle_no_flaga_cstate", {28'd0, cstate}, 32'd0);
    chk("idle_no_flaga_strobes", {28'd0, SLRD, SLWR, SLOE, pktend}, 32'hF);
    chk("idle_fdata_z", {31'd0, FDATA === 16'hzzzz}, 32'd1);

    @(posedge CLK);
    #1;
    flag_en = 1'b1;
    for (int i = 0; i < 4000 && pk_cnt == 0; i++) @(negedge CLK);
    flag_en = 1'b0;
    FLAGA   = 1'b0;
    FLAGD   = 1'b0;
    chk("batch_done_in_time", pk_cnt, 1);
    repeat (4) @(negedge CLK);
    chk("led_after_batch", {28'd0, LED}, 32'd1);
    chk("back_to_idle", {28'd0, cstate}, 32'd0);
    chk("pktend_pulses", pk_cnt, 1);
    chk("slwr_pulses", slwr_cnt, 16);
    chk("wr_queue_drained", exp_wr_addr.size(), 0);
    chk("fx_queue_drained", exp_fx.size(), 0);
    for (int k = 0; k < 8; k++) chk($sformatf("one_write_idx%0d", k), wr_cnt[k], 1);
    chk("mem_word7", mem[7], 32'h000F_000E);
    chk("bus_stable_while_waiting", stab_err, 0);
    chk("strobe_rules", viol, 0);

    // Second batch, aborted by reset while the first memory write is outstanding.
    FLAGA = 1'b1;
    for (int i = 0; i < 50 && cstate != 4'd3; i++) @(negedge CLK);
    chk("reach_wb_wr", {28'd0, cstate}, 32'd3);
    @(negedge CLK);
    rst_n = 1'b1;
    FLAGA = 1'b0;
    @(posedge CLK);
    #1;
    chk("reset_drops_cyc", {30'd0, cyc_i, stb_i}, 32'd0);
    chk("reset_cstate", {28'd0, cstate}, 32'd0);
    @(negedge CLK);
    rst_n = 1'b0;
    repeat (10) @(negedge CLK);
    chk("abort_no_pktend", pk_cnt, 1);
    chk("abort_stays_idle", {28'd0, cstate}, 32'd0);
    chk("abort_led_reset", {28'd0, LED}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
